// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, state encoding and default width for the multiply/divide sequencer
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SMUL = 3'b101;
  localparam logic [2:0] OP_UMUL = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sr_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] r2;
  logic ge;
  always_comb begin
    sum = {1'b0, acc} + (sr[0] ? {1'b0, operand} : '0);
    r2 = {acc, sr[WIDTH-1]};
    ge = r2 >= {1'b0, operand};
    acc_nxt = op == OP_DIV ? (ge ? WIDTH'(r2 - {1'b0, operand}) : r2[WIDTH-1:0]) : sum[WIDTH:1];
    sr_nxt = op == OP_DIV ? {sr[WIDTH-2:0], ge} : {sum[0], sr[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL/SMUL/UMUL/DIV sequencer, one bit per cycle, stalls the core via Busy
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivZero
);
  state_t state, state_nxt;
  logic [CNTW-1:0] cnt;
  logic [2:0] op;
  logic [WIDTH-1:0] acc, sr, opnd, acc_nxt, sr_nxt, mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic neg, accept, dz_req, smul, is_div;
  assign accept = state == IDLE && Start && ALUControl[2];
  assign is_div = ALUControl == OP_DIV;
  assign dz_req = is_div && SrcB == '0;
  assign smul = ALUControl == OP_SMUL;
  // SMUL iterates on magnitudes; 0x80..0 maps to itself, which is its correct unsigned magnitude
  assign mag_a = smul && SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign mag_b = smul && SrcB[WIDTH-1] ? -SrcB : SrcB;
  assign prod = neg ? -{acc, sr} : {acc, sr};
  assign Busy = state == RUN || state == FIX;
  assign Done = state == DONE;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op(op),
    .acc(acc),
    .sr(sr),
    .operand(opnd),
    .acc_nxt(acc_nxt),
    .sr_nxt(sr_nxt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = dz_req ? DONE : RUN;
      RUN: if (cnt == CNTW'(WIDTH - 1)) state_nxt = FIX;
      FIX: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      op <= '0;
      acc <= '0;
      sr <= '0;
      opnd <= '0;
      neg <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      DivZero <= 1'b0;
    end else begin
      if (accept) begin
        op <= ALUControl;
        cnt <= '0;
        acc <= '0;
        opnd <= is_div ? SrcB : mag_a;
        sr <= is_div ? SrcA : mag_b;
        neg <= smul && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
        DivZero <= dz_req;
        if (dz_req) begin
          ResultLo <= '1;
          ResultHi <= SrcA;
        end
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        sr <= sr_nxt;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) {ResultHi, ResultLo} <= prod;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with hand-computed results for muldiv_seq
module tb_muldiv_seq;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Start = 1'b0;
  logic [2:0] ALUControl = '0;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic Busy, Done, DivZero;
  logic [W-1:0] ResultLo, ResultHi;
  int n_chk = 0;
  int n_fail = 0;
  int lat, busy, extra;
  always #5 clk = ~clk;
  muldiv_seq dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .ALUControl(ALUControl),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .Busy(Busy),
    .Done(Done),
    .ResultLo(ResultLo),
    .ResultHi(ResultHi),
    .DivZero(DivZero)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    Start = 1'b1;
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    @(negedge clk);
    Start = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
  endtask
  // lat = number of cycles from the accept cycle to the cycle in which Done is seen
  task automatic wait_done(output int l, output int b);
    l = 1;
    b = 0;
    while (!Done && l < 100) begin
      if (Busy) b++;
      @(negedge clk);
      l++;
    end
    if (!Done) check("done_timeout", Done, 1);
  endtask
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (Done) n++;
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [63:0] exp, input int exp_lat);
    int l, bz;
    start_op(op, a, b);
    wait_done(l, bz);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_busy"}, bz, exp_lat - 1);
    check({tag, "_res"}, {ResultHi, ResultLo}, exp);
    @(negedge clk);
    check({tag, "_pulse"}, Done, 0);
  endtask
  initial begin
    #2;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_res", {ResultHi, ResultLo}, 0);
    check("rst_dz", DivZero, 0);
    @(negedge clk);
    reset = 1'b0;
    run("umul_max", OP_UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, W + 2);
    run("smul_neg", OP_SMUL, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, W + 2);
    run("smul_min", OP_SMUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, W + 2);
    run("smul_min1", OP_SMUL, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, W + 2);
    run("smul_m7", OP_SMUL, 32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9, W + 2);
    run("mul_x2", OP_MUL, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, W + 2);
    run("div_100_7", OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, W + 2);
    check("div_dz0", DivZero, 0);
    run("div_by1", OP_DIV, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, W + 2);
    run("div_dz", OP_DIV, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, 1);
    check("dz_flag", DivZero, 1);
    repeat (3) @(negedge clk);
    check("dz_hold_res", {ResultHi, ResultLo}, 64'h00001234_FFFFFFFF);
    check("dz_hold_flag", DivZero, 1);
    start_op(OP_DIV, 32'd100, 32'd7);
    check("dz_clear", DivZero, 0);
    check("res_hold_run", {ResultHi, ResultLo}, 64'h00001234_FFFFFFFF);
    wait_done(lat, busy);
    check("div2_res", {ResultHi, ResultLo}, {32'd2, 32'd14});
    start_op(OP_MUL, 32'h00012345, 32'h00000111);
    repeat (4) @(negedge clk);
    Start = 1'b1;
    ALUControl = OP_UMUL;
    SrcA = 32'd5;
    SrcB = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    wait_done(lat, busy);
    check("inflight_res", {ResultHi, ResultLo}, 64'h00000000_01369C95);
    count_done(40, extra);
    check("no_extra_done", extra, 0);
    check("idle_busy", Busy, 0);
    start_op(3'b010, 32'd9, 32'd9);
    check("alu_ignored_busy", Busy, 0);
    count_done(5, extra);
    check("alu_ignored_done", extra, 0);
    check("alu_ignored_res", {ResultHi, ResultLo}, 64'h00000000_01369C95);
    start_op(OP_MUL, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_res", {ResultHi, ResultLo}, 0);
    @(negedge clk);
    reset = 1'b0;
    count_done(40, extra);
    check("abort_no_done", extra, 0);
    run("mul_6_7", OP_MUL, 32'd6, 32'd7, 64'd42, W + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
